alu_rr_arbiter: RTL and testbench

//  Shares the single 32-bit ALU (AND/OR/NOR/ADD/SUB/MUL) between up to 4 requesters (e.g. core datapath, debug port, coprocessor).

---
 rtl/alu_rr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one 32-bit ALU among NUM_REQ requesters.
// One operation in flight: IDLE (arbitrate/accept) -> EXEC (ALU evaluates) -> RESP (hold response).
module alu_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int MAX_OP  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [4*NUM_REQ-1:0]  req_op,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [3:0]            alu_op,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  input  logic [31:0]           alu_result,
  input  logic                  alu_zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [1:0]            rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  rsp_zero,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  id_q, id_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_id_q, rsp_id_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_err_q, rsp_err_d;

  logic        gnt_found;
  logic [1:0]  gnt_idx;
  logic [3:0]  sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;

  // Round-robin search: indices above the last grant first, then wrap to the rest.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && (i > int'(last_q)) && req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = 2'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && (i <= int'(last_q)) && req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = 2'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == 2'(i)) begin
        sel_op = req_op[4*i +: 4];
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
      end
    end
  end

  // One-hot accept, only while idle and never during reset.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = !reset && (state_q == IDLE) && gnt_found && (gnt_idx == 2'(i));
    end
  end

  // Next-state and next-register values for the accept/execute/respond sequence.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    id_d         = id_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          alu_op_d = sel_op;
          alu_a_d  = sel_a;
          alu_b_d  = sel_b;
          id_d     = gnt_idx;
          last_d   = gnt_idx;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_err_d    = (alu_op_q > 4'(MAX_OP));
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any in-flight operation without a response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= 2'(NUM_REQ - 1);
      id_q         <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      id_q         <= id_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Testbench for alu_rr_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level round-robin/ALU reference model.
module tb_alu_rr_arbiter;
  localparam int NUM_REQ = 2;
  localparam int MAX_OP  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid, req_ready;
  logic [4*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_a, req_b;
  logic [3:0]            alu_op;
  logic [31:0]           alu_a, alu_b, alu_result;
  logic                  alu_zero;
  logic                  rsp_valid, rsp_ready;
  logic [1:0]            rsp_id;
  logic [31:0]           rsp_result;
  logic                  rsp_zero, rsp_err;

  alu_rr_arbiter #(.NUM_REQ(NUM_REQ), .MAX_OP(MAX_OP)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // ALU behaviour: AND, OR, NOR, ADD, SUB, MUL(A*B-1); anything above MUL returns 0.
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return ~(a | b);
      4'd3:    return a + b;
      4'd4:    return a - b;
      4'd5:    return a * b - 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == 32'd0);

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  // Requester-side drive state
  logic        drv_v  [NUM_REQ];
  logic [3:0]  drv_op [NUM_REQ];
  logic [31:0] drv_a  [NUM_REQ];
  logic [31:0] drv_b  [NUM_REQ];
  logic        acc    [NUM_REQ];
  op_t         pend   [NUM_REQ][64];
  int          wr_p   [NUM_REQ];
  int          rd_p   [NUM_REQ];

  always_comb begin
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]       = drv_v[i];
      req_op[4*i +: 4]   = drv_op[i];
      req_a[32*i +: 32]  = drv_a[i];
      req_b[32*i +: 32]  = drv_b[i];
    end
  end

  // Reference model state (transaction level)
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          m_busy;
  int          m_last;
  int          m_gcyc;
  int          m_id;
  logic [31:0] m_res;
  logic        m_zero, m_err;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b;
  int          grants [NUM_REQ];

  // Stimulus controls
  int rst_left;
  bit rst_seen_edge;
  int rdy_force;
  bit rand_mode;
  bit wd_en;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    pend[r][wr_p[r] % 64] = '{op: op, a: a, b: b};
    wr_p[r]++;
  endtask

  task automatic rand_op(input int r);
    drv_op[r] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
    drv_a[r]  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
    drv_b[r]  = ($urandom_range(0, 3) == 0) ? drv_a[r] : $urandom;
    drv_v[r]  = 1'b1;
  endtask

  task automatic check_cycle();
    int  w;
    bit  exp_v;
    w = -1;
    if (!m_busy) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int i;
        i = (m_last + k) % NUM_REQ;
        if (w < 0 && drv_v[i]) w = i;
      end
      chk("req_ready", 64'(req_ready), (w >= 0) ? 64'(1 << w) : 64'd0);
      if (w >= 0) begin
        m_busy = 1'b1;
        m_gcyc = cyc;
        m_last = w;
        m_id   = w;
        m_op   = drv_op[w];
        m_a    = drv_a[w];
        m_b    = drv_b[w];
        m_res  = alu_fn(drv_op[w], drv_a[w], drv_b[w]);
        m_zero = (m_res == 32'd0);
        m_err  = (int'(drv_op[w]) > MAX_OP);
        grants[w]++;
      end
    end else begin
      chk("req_ready_busy", 64'(req_ready), 64'd0);
      chk("alu_op_hold", 64'(alu_op), 64'(m_op));
      chk("alu_a_hold", 64'(alu_a), 64'(m_a));
      chk("alu_b_hold", 64'(alu_b), 64'(m_b));
    end
    exp_v = m_busy && (cyc >= m_gcyc + 2);
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
    if (exp_v && rsp_valid) begin
      chk("rsp_id", 64'(rsp_id), 64'(m_id));
      chk("rsp_result", 64'(rsp_result), 64'(m_res));
      chk("rsp_zero", 64'(rsp_zero), 64'(m_zero));
      chk("rsp_err", 64'(rsp_err), 64'(m_err));
      if (rsp_ready) m_busy = 1'b0;
    end
    for (int i = 0; i < NUM_REQ; i++) acc[i] = req_valid[i] & req_ready[i];
  endtask

  // One clock: drive after posedge, observe and check at negedge.
  task automatic step();
    @(posedge clk);
    #1;
    reset = (rst_left > 0);
    if (rst_left > 0) rst_left--;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!drv_v[i] || acc[i]) begin
        if (rd_p[i] != wr_p[i]) begin
          drv_op[i] = pend[i][rd_p[i] % 64].op;
          drv_a[i]  = pend[i][rd_p[i] % 64].a;
          drv_b[i]  = pend[i][rd_p[i] % 64].b;
          drv_v[i]  = 1'b1;
          rd_p[i]++;
        end else if (rand_mode && $urandom_range(0, 2) == 0) begin
          rand_op(i);
        end else begin
          drv_v[i] = 1'b0;
        end
      end else if (wd_en && $urandom_range(0, 15) == 0) begin
        drv_v[i] = 1'b0;
      end
    end
    rsp_ready = (rdy_force >= 0) ? rdy_force[0] : ($urandom_range(0, 2) != 0);
    @(negedge clk);
    cyc++;
    if (reset) begin
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      if (rst_seen_edge) begin
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_result", 64'(rsp_result), 64'd0);
        chk("rst_rsp_zero_err", 64'({rsp_zero, rsp_err}), 64'd0);
        chk("rst_alu_regs", {28'd0, alu_op, alu_a}, 64'd0);
        chk("rst_alu_b", 64'(alu_b), 64'd0);
      end
      rst_seen_edge = 1'b1;
      m_busy = 1'b0;
      m_last = NUM_REQ - 1;
      for (int i = 0; i < NUM_REQ; i++) acc[i] = 1'b0;
    end else begin
      rst_seen_edge = 1'b0;
      check_cycle();
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    reset = 1'b1;
    rsp_ready = 1'b0;
    rst_left = 3;
    rst_seen_edge = 1'b0;
    rdy_force = 1;
    rand_mode = 1'b0;
    wd_en = 1'b0;
    m_busy = 1'b0;
    m_last = NUM_REQ - 1;
    m_gcyc = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      drv_v[i] = 1'b0; drv_op[i] = '0; drv_a[i] = '0; drv_b[i] = '0;
      acc[i] = 1'b0; wr_p[i] = 0; rd_p[i] = 0; grants[i] = 0;
    end

    // Both requesters valid from reset: grants alternate 0,1,0,1,...
    for (int k = 0; k < 3; k++) begin
      push(0, 4'd3, 32'(100 + k), 32'd1);
      push(1, 4'd4, 32'(200 + k), 32'd2);
    end
    run(30);
    chk("alt_grants_0", 64'(grants[0]), 64'd3);
    chk("alt_grants_1", 64'(grants[1]), 64'd3);

    // ADD 5+7, SUB 9-9 (zero), MUL 3*4-1
    push(0, 4'd3, 32'd5, 32'd7);
    push(1, 4'd4, 32'd9, 32'd9);
    push(1, 4'd5, 32'd3, 32'd4);
    run(15);

    // Consumer stalls: response must hold, no new grant while held
    rdy_force = 0;
    push(0, 4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF);
    push(0, 4'd1, 32'h1, 32'h2);
    run(8);
    rdy_force = 1;
    run(10);

    // Illegal op then legal op
    push(0, 4'hF, 32'd1, 32'd1);
    push(0, 4'd2, 32'd1, 32'd1);
    run(10);

    // Reset while an operation is executing
    push(1, 4'd3, 32'd11, 32'd22);
    push(0, 4'd3, 32'd1, 32'd2);
    push(0, 4'd3, 32'd3, 32'd4);
    begin
      int budget;
      budget = 0;
      while (!m_busy && budget < 10) begin
        step();
        budget++;
      end
      chk("exec_reset_grant_seen", 64'(m_busy), 64'd1);
    end
    rst_left = 1;
    step();
    grants[0] = 0;
    grants[1] = 0;
    step();
    chk("post_reset_first_grant_req0", 64'(grants[0]), 64'd1);
    run(20);

    // Randomized traffic with withdrawals and consumer back-pressure
    rand_mode = 1'b1;
    wd_en = 1'b1;
    rdy_force = -1;
    run(3000);
    rand_mode = 1'b0;
    wd_en = 1'b0;
    rdy_force = 1;
    run(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
